// File: rtl/dili_modaddsub.sv
// Two-stage pipelined modular add/subtract, (a +/- b) mod Q on LANES lanes, valid/ready on both sides.
// Optional per-lane input range flags on err_o when DILI_MODADDSUB_RANGECHK_EN is defined.
module dili_modaddsub #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned Q          = 8380417,
  parameter int unsigned LANES      = 1
) (
  input  logic                        clk_i,
  input  logic                        rstn,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic                        op_i,
  input  logic [LANES*DATA_WIDTH-1:0] a_i,
  input  logic [LANES*DATA_WIDTH-1:0] b_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
`ifdef DILI_MODADDSUB_RANGECHK_EN
  output logic [LANES-1:0]            err_o,
`endif
  output logic [LANES*DATA_WIDTH-1:0] res_o
);

  localparam int unsigned RW = DATA_WIDTH + 1;
  localparam logic [RW-1:0]         Q_R = RW'(Q);
  localparam logic [DATA_WIDTH-1:0] Q_D = DATA_WIDTH'(Q);

  // Raw sum/difference, one extra bit holds the carry or the sign.
  function automatic logic [RW-1:0] raw_lane(input logic op, input logic [DATA_WIDTH-1:0] a,
                                             input logic [DATA_WIDTH-1:0] b);
    logic [RW-1:0] r;
    if (op) begin
      r = {1'b0, a} - {1'b0, b};
    end else begin
      r = {1'b0, a} + {1'b0, b};
    end
    return r;
  endfunction

  // Single conditional correction back into [0, Q) for in-range operands.
  function automatic logic [DATA_WIDTH-1:0] corr_lane(input logic op, input logic [RW-1:0] r);
    logic [RW-1:0] t;
    if (op) begin
      if (r[RW-1]) begin
        t = r + Q_R;
      end else begin
        t = r;
      end
    end else begin
      if (r >= Q_R) begin
        t = r - Q_R;
      end else begin
        t = r;
      end
    end
    return t[DATA_WIDTH-1:0];
  endfunction

  logic                        s1_v_q, s2_v_q, s1_op_q;
  logic [LANES*RW-1:0]         s1_raw_q, s1_raw_d;
  logic [LANES*DATA_WIDTH-1:0] s2_res_q, s2_res_d;
  logic                        s1_load_s, s2_load_s;

  // Stage enables; in_ready_o is combinational from out_ready_i.
  always_comb begin
    s2_load_s  = !s2_v_q || out_ready_i;
    s1_load_s  = !s1_v_q || s2_load_s;
    in_ready_o = s1_load_s;
  end

  // Per-lane next-state data for both stages.
  always_comb begin
    s1_raw_d = '0;
    s2_res_d = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      s1_raw_d[k*RW +: RW] = raw_lane(op_i, a_i[k*DATA_WIDTH +: DATA_WIDTH],
                                      b_i[k*DATA_WIDTH +: DATA_WIDTH]);
      s2_res_d[k*DATA_WIDTH +: DATA_WIDTH] = corr_lane(s1_op_q, s1_raw_q[k*RW +: RW]);
    end
  end

  // Pipeline valids and data; data only moves on a valid transfer.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      s1_op_q  <= 1'b0;
      s1_raw_q <= '0;
      s2_res_q <= '0;
    end else begin
      if (s2_load_s) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          s2_res_q <= s2_res_d;
        end
      end
      if (s1_load_s) begin
        s1_v_q <= in_valid_i;
        if (in_valid_i) begin
          s1_op_q  <= op_i;
          s1_raw_q <= s1_raw_d;
        end
      end
    end
  end

  assign out_valid_o = s2_v_q;
  assign res_o       = s2_res_q;

`ifdef DILI_MODADDSUB_RANGECHK_EN
  function automatic logic range_bad(input logic [DATA_WIDTH-1:0] a,
                                     input logic [DATA_WIDTH-1:0] b);
    return (a >= Q_D) || (b >= Q_D);
  endfunction

  logic [LANES-1:0] s1_err_q, s1_err_d, s2_err_q;

  // Per-lane range flags for the incoming beat.
  always_comb begin
    s1_err_d = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      s1_err_d[k] = range_bad(a_i[k*DATA_WIDTH +: DATA_WIDTH], b_i[k*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Range flags travel alongside the data with the same enables.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      s1_err_q <= '0;
      s2_err_q <= '0;
    end else begin
      if (s2_load_s && s1_v_q) begin
        s2_err_q <= s1_err_q;
      end
      if (s1_load_s && in_valid_i) begin
        s1_err_q <= s1_err_d;
      end
    end
  end

  assign err_o = s2_err_q & {LANES{s2_v_q}};
`else
  localparam logic [DATA_WIDTH-1:0] Q_D_UNUSED = Q_D;
`endif

endmodule

// File: tb/tb_dili_modaddsub.sv
// Self-checking bench for dili_modaddsub (LANES=4): table vectors, latency, backpressure,
// full-throughput random stream and mid-stream reset, checked through a scoreboard queue.
module tb_dili_modaddsub;
  localparam int unsigned DW = 32;
  localparam int unsigned LN = 4;
  localparam int unsigned QM = 8380417;

  typedef struct {
    bit          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [LN*DW-1:0] res;
    logic [LN-1:0]    err;
  } sb_t;

  logic             clk_i = 1'b0;
  logic             rstn;
  logic             in_valid_i, op_i, out_ready_i;
  logic             in_ready_o, out_valid_o;
  logic [LN*DW-1:0] a_i, b_i, res_o;
`ifdef DILI_MODADDSUB_RANGECHK_EN
  logic [LN-1:0]    err_o;
`endif

  int checks = 0;
  int failures = 0;

  sb_t              sb_q[$];
  vec_t             vecs[11];
  bit               drv_valid, drv_op, out_rdy;
  logic [LN*DW-1:0] drv_a, drv_b, drv_exp;
  logic [LN-1:0]    drv_err;
  bit               samp_rdy;
  logic [LN*DW-1:0] samp_res;

  dili_modaddsub #(.DATA_WIDTH(DW), .Q(QM), .LANES(LN)) dut (
    .clk_i(clk_i), .rstn(rstn),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .op_i(op_i),
    .a_i(a_i), .b_i(b_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
`ifdef DILI_MODADDSUB_RANGECHK_EN
    .err_o(err_o),
`endif
    .res_o(res_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mod_ref(bit op, logic [31:0] a, logic [31:0] b);
    longint x;
    if (!op) x = (longint'(a) + longint'(b)) % longint'(QM);
    else     x = ((longint'(a) - longint'(b)) % longint'(QM) + longint'(QM)) % longint'(QM);
    return x[31:0];
  endfunction

  task automatic chk(string nm, logic [LN*DW-1:0] act, logic [LN*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Lane 0 gets the given operands/result; lanes 1..3 random in-range with model result.
  task automatic set_beat(bit op, logic [31:0] a0, logic [31:0] b0, logic [31:0] e0);
    logic [31:0] a, b;
    drv_op = op;
    drv_a[31:0] = a0; drv_b[31:0] = b0; drv_exp[31:0] = e0;
    drv_err[0] = (a0 >= QM) || (b0 >= QM);
    for (int k = 1; k < int'(LN); k++) begin
      a = $urandom_range(QM - 1, 0);
      b = $urandom_range(QM - 1, 0);
      drv_a[k*DW +: DW] = a; drv_b[k*DW +: DW] = b;
      drv_exp[k*DW +: DW] = mod_ref(op, a, b);
      drv_err[k] = 1'b0;
    end
  endtask

  task automatic set_rand_beat();
    logic [31:0] a, b;
    bit op;
    op = 1'($urandom_range(1, 0));
    a = $urandom_range(QM - 1, 0);
    b = $urandom_range(QM - 1, 0);
    set_beat(op, a, b, mod_ref(op, a, b));
  endtask

  task automatic apply();
    in_valid_i = drv_valid; op_i = drv_op; a_i = drv_a; b_i = drv_b; out_ready_i = out_rdy;
  endtask

  // One clock: drive at negedge, sample handshakes 1ns later, then wait for the edge.
  task automatic step(output bit acc, output bit fire);
    sb_t e;
    @(negedge clk_i);
    apply();
    #1;
    samp_rdy = in_ready_o;
    samp_res = res_o;
    acc  = in_valid_i && in_ready_o;
    fire = out_valid_o && out_ready_i;
    if (acc) sb_q.push_back('{res: drv_exp, err: drv_err});
    if (fire) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_beat", 128'd1, 128'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_res", res_o, e.res);
`ifdef DILI_MODADDSUB_RANGECHK_EN
        chk("sb_err", {124'd0, err_o}, {124'd0, e.err});
`endif
      end
    end
    @(posedge clk_i);
  endtask

  task automatic drain(string nm);
    bit acc, fire;
    drv_valid = 1'b0; out_rdy = 1'b1;
    for (int c = 0; c < 50 && sb_q.size() > 0; c++) step(acc, fire);
    chk(nm, 128'(sb_q.size()), 128'd0);
    sb_q.delete();
  endtask

  // Single isolated beat: low after the capture edge, valid with result after the next one.
  task automatic latency_test(string nm, bit op, logic [31:0] a, logic [31:0] b, logic [31:0] e);
    set_beat(op, a, b, e);
    out_rdy = 1'b1; drv_valid = 1'b1;
    @(negedge clk_i); apply(); #1;
    chk({nm, "_in_ready"}, 128'(in_ready_o), 128'd1);
    @(posedge clk_i);
    @(negedge clk_i); in_valid_i = 1'b0; drv_valid = 1'b0; #1;
    chk({nm, "_valid_early"}, 128'(out_valid_o), 128'd0);
    @(posedge clk_i);
    @(negedge clk_i); #1;
    chk({nm, "_valid"}, 128'(out_valid_o), 128'd1);
    chk({nm, "_res"}, res_o, drv_exp);
    @(posedge clk_i);
    @(negedge clk_i); #1;
    chk({nm, "_valid_drop"}, 128'(out_valid_o), 128'd0);
  endtask

  initial begin
    bit acc, fire;
    int sent, fires, first_fire, n;
    logic [LN*DW-1:0] held;

    vecs[0]  = '{1'b0, 32'd5,       32'd7,       32'd12};
    vecs[1]  = '{1'b0, 32'd8380416, 32'd1,       32'd0};
    vecs[2]  = '{1'b0, 32'd8380416, 32'd8380416, 32'd8380415};
    vecs[3]  = '{1'b1, 32'd0,       32'd1,       32'd8380416};
    vecs[4]  = '{1'b1, 32'd3,       32'd3,       32'd0};
    vecs[5]  = '{1'b0, 32'd0,       32'd0,       32'd0};
    vecs[6]  = '{1'b1, 32'd8380416, 32'd0,       32'd8380416};
    vecs[7]  = '{1'b0, 32'd4190208, 32'd4190209, 32'd0};
    vecs[8]  = '{1'b0, 32'd100,     32'd200,     32'd300};
    vecs[9]  = '{1'b1, 32'd1,       32'd8380416, 32'd2};
    vecs[10] = '{1'b0, 32'd8380417, 32'd0,       32'd0};

    rstn = 1'b0; drv_valid = 1'b0; out_rdy = 1'b0;
    drv_op = 1'b0; drv_a = '0; drv_b = '0; drv_exp = '0; drv_err = '0;
    apply();
    #12;
    chk("rst_out_valid", 128'(out_valid_o), 128'd0);
    chk("rst_in_ready", 128'(in_ready_o), 128'd1);
    chk("rst_res", res_o, 128'd0);
`ifdef DILI_MODADDSUB_RANGECHK_EN
    chk("rst_err", 128'(err_o), 128'd0);
`endif
    @(negedge clk_i); rstn = 1'b1;

    latency_test("lat_basic", 1'b0, 32'd5, 32'd7, 32'd12);

    // Table vectors, one beat each, through the scoreboard.
    out_rdy = 1'b1;
    for (int i = 0; i < 11; i++) begin
      set_beat(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      drv_valid = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 20 && !acc; c++) step(acc, fire);
      chk("table_accept", 128'(acc), 128'd1);
    end
    drain("table_drain");
`ifdef DILI_MODADDSUB_RANGECHK_EN
    @(negedge clk_i); #1;
    chk("idle_err", 128'(err_o), 128'd0);
`endif

    // Backpressure: 6 beats, downstream stalled in cycles 1-4.
    sent = 0; fires = 0; held = '0;
    set_rand_beat();
    for (int c = 0; c < 40 && (sent < 6 || sb_q.size() > 0); c++) begin
      out_rdy = !(c >= 1 && c <= 4);
      drv_valid = (sent < 6);
      step(acc, fire);
      if (fire) fires++;
      if (c >= 2 && c <= 4) chk("bp_in_ready_low", 128'(samp_rdy), 128'd0);
      if (c == 2) held = samp_res;
      if (c == 3 || c == 4) chk("bp_res_stable", samp_res, held);
      if (acc) begin
        sent++;
        if (sent < 6) set_rand_beat();
      end
    end
    chk("bp_sent", 128'(sent), 128'd6);
    chk("bp_fires", 128'(fires), 128'd6);
    drain("bp_drain");

    // Full throughput: 100 random beats, ready held high.
    out_rdy = 1'b1; fires = 0; first_fire = -1; n = 0;
    set_rand_beat();
    for (int c = 0; c < 102; c++) begin
      drv_valid = (n < 100);
      step(acc, fire);
      if (fire) begin
        fires++;
        if (first_fire < 0) first_fire = c;
      end
      if (acc) begin
        n++;
        set_rand_beat();
      end
    end
    chk("tp_accepted", 128'(n), 128'd100);
    chk("tp_fires", 128'(fires), 128'd100);
    chk("tp_first_fire", 128'(first_fire), 128'd2);
    drain("tp_drain");

    // Reset with both stages holding beats.
    out_rdy = 1'b0; drv_valid = 1'b1;
    set_rand_beat(); step(acc, fire);
    set_rand_beat(); step(acc, fire);
    drv_valid = 1'b0;
    @(negedge clk_i); apply(); #1;
    chk("mid_full", 128'({out_valid_o, in_ready_o}), 128'b10);
    rstn = 1'b0; #1;
    chk("mid_rst_out_valid", 128'(out_valid_o), 128'd0);
    chk("mid_rst_in_ready", 128'(in_ready_o), 128'd1);
    chk("mid_rst_res", res_o, 128'd0);
    sb_q.delete();
    @(negedge clk_i); rstn = 1'b1;
    latency_test("lat_after_rst", 1'b0, 32'd1, 32'd2, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
